// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the Avalon memory arbiter: FSM states,
// owner codes and the stall watchdog limit.
package avl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_RD  = 2'd1,
    GNT_WR0 = 2'd2,
    GNT_WR1 = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RD   = 2'd1;
  localparam logic [1:0] OWN_WR0  = 2'd2;
  localparam logic [1:0] OWN_WR1  = 2'd3;

  // Consecutive unaccepted command cycles tolerated before stall_err fires
  localparam int unsigned WDT_LIMIT = 1024;

endpackage

// File: rtl/avl_arb_outst.sv
// Outstanding-read tracker: counts issued reads not yet returned and flags
// when the read window is full.
module avl_arb_outst #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [CNT_W-1:0] cnt_p0;

  // Returns arriving with nothing tracked (e.g. after a reset) must not wrap
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic up,
                                                input logic dn);
    if (up && !dn) return c + 1'b1;
    if (dn && !up && c != '0) return c - 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_p0 <= '0;
    else        cnt_p0 <= sat_step(cnt_p0, inc, dec);
  end

  assign full = (cnt_p0 == CNT_W'(MAX_OUTST));

endmodule

// File: rtl/avl_mem_arbiter.sv
// Three-requester Avalon arbiter (display read, two camera writers) with read
// priority, writer round-robin and burst limiting. AVL_ARB_WDT_EN adds stall_err.
module avl_mem_arbiter
  import avl_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int BURST_LEN  = 16,
  parameter int MAX_OUTST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_rdy,
  input  logic                  wr0_req,
  input  logic                  wr1_req,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr0_gnt,
  output logic                  wr1_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  avl_ready,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [DATA_WIDTH-1:0] avl_wdata,
  input  logic [DATA_WIDTH-1:0] avl_rdata,
  input  logic                  avl_rdata_valid,
`ifdef AVL_ARB_WDT_EN
  output logic [1:0]            owner,
  output logic                  stall_err
`else
  output logic [1:0]            owner
`endif
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  arb_state_t        state_p0, state_d;
  logic [BEAT_W-1:0] beat_cnt_p0;
  logic              rr_wr1_p0;
  logic              outst_full;
  logic              req_raw, cmd, accept;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic              vld_p1;

  avl_arb_outst #(.MAX_OUTST(MAX_OUTST)) u_outst (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_gnt),
    .dec   (avl_rdata_valid),
    .full  (outst_full)
  );

  always_comb begin
    req_raw       = 1'b0;
    avl_addr      = '0;
    avl_wdata     = '0;
    state_d       = state_p0;
    case (state_p0)
      GNT_RD:  begin req_raw = rd_req;  avl_addr = rd_addr; end
      GNT_WR0: begin req_raw = wr0_req; avl_addr = wr0_addr; avl_wdata = wr0_data; end
      GNT_WR1: begin req_raw = wr1_req; avl_addr = wr1_addr; avl_wdata = wr1_data; end
      default: ;
    endcase
    // A full read window parks the read grant without issuing
    cmd    = req_raw & ram_rdy & ~((state_p0 == GNT_RD) & outst_full);
    accept = cmd & avl_ready;

    avl_read_req  = cmd & (state_p0 == GNT_RD);
    avl_write_req = cmd & ((state_p0 == GNT_WR0) | (state_p0 == GNT_WR1));
    rd_gnt        = accept & (state_p0 == GNT_RD);
    wr0_gnt       = accept & (state_p0 == GNT_WR0);
    wr1_gnt       = accept & (state_p0 == GNT_WR1);

    if (state_p0 == IDLE) begin
      if (ram_rdy) begin
        if (rd_req && !outst_full)  state_d = GNT_RD;
        else if (wr0_req && wr1_req) state_d = rr_wr1_p0 ? GNT_WR1 : GNT_WR0;
        else if (wr0_req)            state_d = GNT_WR0;
        else if (wr1_req)            state_d = GNT_WR1;
      end
    end else if (!ram_rdy || !req_raw ||
                 (accept && beat_cnt_p0 == BEAT_W'(BURST_LEN - 1))) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0    <= IDLE;
      beat_cnt_p0 <= '0;
      rr_wr1_p0   <= 1'b0;
    end else begin
      state_p0 <= state_d;
      if (state_p0 == IDLE) beat_cnt_p0 <= '0;
      else if (accept)      beat_cnt_p0 <= beat_cnt_p0 + 1'b1;
      if ((state_p0 == GNT_WR0 || state_p0 == GNT_WR1) && state_d != state_p0)
        rr_wr1_p0 <= (state_p0 == GNT_WR0);
    end
  end

  // Stage p1: read-return register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      rd_data_p1 <= avl_rdata;
      vld_p1     <= avl_rdata_valid;
    end
  end

  assign rd_data       = rd_data_p1;
  assign rd_data_valid = vld_p1;
  assign owner         = state_p0;

`ifdef AVL_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);
  logic [WDT_W-1:0] stall_cnt_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_p0 <= '0;
      stall_err    <= 1'b0;
    end else if (cmd && !avl_ready) begin
      if (stall_cnt_p0 == WDT_W'(WDT_LIMIT)) stall_err <= 1'b1;
      else                                    stall_cnt_p0 <= stall_cnt_p0 + 1'b1;
    end else begin
      stall_cnt_p0 <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// Directed self-checking bench for avl_mem_arbiter (default configuration).
module tb_avl_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 29;

  logic          clk, reset, ram_rdy;
  logic          wr0_req, wr1_req, rd_req;
  logic [AW-1:0] wr0_addr, wr1_addr, rd_addr, avl_addr;
  logic [DW-1:0] wr0_data, wr1_data, rd_data, avl_wdata, avl_rdata;
  logic          wr0_gnt, wr1_gnt, rd_gnt, rd_data_valid;
  logic          avl_ready, avl_write_req, avl_read_req, avl_rdata_valid;
  logic [1:0]    owner;

  int checks = 0;
  int failures = 0;

  avl_mem_arbiter dut (
    .clk(clk), .reset(reset), .ram_rdy(ram_rdy),
    .wr0_req(wr0_req), .wr1_req(wr1_req),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .wr0_gnt(wr0_gnt), .wr1_gnt(wr1_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .avl_ready(avl_ready), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ram_rdy = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
    wr0_addr = '0; wr1_addr = '0; rd_addr = '0; wr0_data = '0; wr1_data = '0;
    avl_ready = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ram_rdy = 1'b1; wr0_req = 1'b1; avl_ready = 1'b1;
    avl_rdata = 32'hCAFE_F00D; avl_rdata_valid = 1'b1;
    reset = 1'b0;
    #2;
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++; if (avl_write_req !== 1'b0) begin failures++; $display("FAIL reset_wcmd got=%b exp=0", avl_write_req); end
    checks++; if (wr0_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", wr0_gnt); end
    checks++; if (avl_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", avl_addr); end
    @(posedge clk); #1;
    checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rd_data_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rd_data); end
    do_reset();
    @(negedge clk);
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_idle_owner got=%0d exp=0", owner); end
    @(posedge clk); #1;
  endtask

  task automatic test_wr0_burst();
    int beats = 0;
    logic g;
    logic [1:0] exp_o;
    logic exp_g;
    do_reset();
    ram_rdy = 1'b1; avl_ready = 1'b1; wr0_req = 1'b1;
    wr0_addr = AW'(29'h100); wr0_data = 32'hA000_0000;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      exp_g = (c >= 1 && c <= 16) || (c >= 18 && c <= 21);
      exp_o = (c == 0 || c == 17) ? 2'd0 : 2'd2;
      checks++; if (wr0_gnt !== exp_g) begin failures++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, wr0_gnt, exp_g); end
      checks++; if (owner !== exp_o) begin failures++; $display("FAIL burst_owner c=%0d got=%0d exp=%0d", c, owner, exp_o); end
      if (exp_g) begin
        checks++;
        if (avl_addr !== AW'(29'h100 + beats) || avl_wdata !== 32'hA000_0000 + 32'(beats)) begin
          failures++; $display("FAIL burst_addr c=%0d got=%h/%h exp=%h", c, avl_addr, avl_wdata, 29'h100 + beats);
        end
      end
      g = wr0_gnt;
      @(posedge clk); #1;
      if (g) beats++;
      wr0_addr = AW'(29'h100 + beats); wr0_data = 32'hA000_0000 + 32'(beats);
      if (beats == 20) wr0_req = 1'b0;
    end
    @(negedge clk);
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL burst_end_owner got=%0d exp=0", owner); end
    checks++; if (beats !== 20) begin failures++; $display("FAIL burst_beats got=%0d exp=20", beats); end
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    logic g0, g1;
    logic [1:0] exp_o;
    do_reset();
    ram_rdy = 1'b1; avl_ready = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
    wr0_addr = AW'(29'h1000); wr1_addr = AW'(29'h2000);
    for (int c = 0; c <= 35; c++) begin
      @(negedge clk);
      if (c == 0 || c == 17 || c == 34) exp_o = 2'd0;
      else if (c <= 16 || c == 35)      exp_o = 2'd2;
      else                              exp_o = 2'd3;
      checks++; if (owner !== exp_o) begin failures++; $display("FAIL rr_owner c=%0d got=%0d exp=%0d", c, owner, exp_o); end
      checks++; if (wr0_gnt !== (exp_o == 2'd2) || wr1_gnt !== (exp_o == 2'd3)) begin
        failures++; $display("FAIL rr_gnt c=%0d got=%b%b exp_owner=%0d", c, wr0_gnt, wr1_gnt, exp_o);
      end
      if (exp_o == 2'd3) begin
        checks++; if (avl_addr !== AW'(29'h2000 + n1)) begin failures++; $display("FAIL rr_addr1 c=%0d got=%h exp=%h", c, avl_addr, 29'h2000 + n1); end
      end
      g0 = wr0_gnt; g1 = wr1_gnt;
      @(posedge clk); #1;
      if (g0) n0++;
      if (g1) n1++;
      wr0_addr = AW'(29'h1000 + n0); wr1_addr = AW'(29'h2000 + n1);
    end
    checks++; if (n0 !== 17 || n1 !== 16) begin failures++; $display("FAIL rr_counts got=%0d/%0d exp=17/16", n0, n1); end
  endtask

  task automatic test_rd_priority();
    do_reset();
    ram_rdy = 1'b1; avl_ready = 1'b1;
    rd_req = 1'b1; rd_addr = AW'(29'h55); wr0_req = 1'b1; wr0_addr = AW'(29'h10);
    @(negedge clk);
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL prio_c0_owner got=%0d exp=0", owner); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL prio_owner got=%0d exp=1", owner); end
    checks++; if (avl_read_req !== 1'b1 || avl_write_req !== 1'b0) begin failures++; $display("FAIL prio_cmd got=r%b w%b exp=r1 w0", avl_read_req, avl_write_req); end
    checks++; if (rd_gnt !== 1'b1 || wr0_gnt !== 1'b0) begin failures++; $display("FAIL prio_gnt got=r%b w%b exp=r1 w0", rd_gnt, wr0_gnt); end
    checks++; if (avl_addr !== AW'(29'h55)) begin failures++; $display("FAIL prio_addr got=%h exp=55", avl_addr); end
    @(posedge clk); #1;
    rd_req = 1'b0; avl_rdata = 32'hDEAD_BEEF; avl_rdata_valid = 1'b1;
    @(negedge clk);
    checks++; if (rd_data_valid !== 1'b0) begin failures++; $display("FAIL rdlat_early got=%b exp=0", rd_data_valid); end
    @(posedge clk); #1;
    avl_rdata_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_data_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rdlat_data got=%b/%h exp=1/deadbeef", rd_data_valid, rd_data);
    end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL prio_idle got=%0d exp=0", owner); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if (owner !== 2'd2 || wr0_gnt !== 1'b1) begin failures++; $display("FAIL prio_wr_after got=%0d/%b exp=2/1", owner, wr0_gnt); end
    @(posedge clk); #1;
    wr0_req = 1'b0;
  endtask

  task automatic test_stall();
    int beats = 0;
    logic g, exp_g;
    logic [1:0] exp_o;
    do_reset();
    ram_rdy = 1'b1; wr0_req = 1'b1; wr0_addr = AW'(29'h300);
    for (int c = 0; c <= 22; c++) begin
      avl_ready = !(c >= 4 && c <= 8);
      @(negedge clk);
      exp_g = (c >= 1 && c <= 3) || (c >= 9 && c <= 21);
      exp_o = (c == 0 || c == 22) ? 2'd0 : 2'd2;
      checks++; if (wr0_gnt !== exp_g) begin failures++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, wr0_gnt, exp_g); end
      checks++; if (owner !== exp_o) begin failures++; $display("FAIL stall_owner c=%0d got=%0d exp=%0d", c, owner, exp_o); end
      if (c >= 4 && c <= 8) begin
        checks++; if (avl_write_req !== 1'b1 || avl_addr !== AW'(29'h303)) begin
          failures++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/303", c, avl_write_req, avl_addr);
        end
      end
      g = wr0_gnt;
      @(posedge clk); #1;
      if (g) beats++;
      wr0_addr = AW'(29'h300 + beats);
    end
    checks++; if (beats !== 16) begin failures++; $display("FAIL stall_beats got=%0d exp=16", beats); end
    wr0_req = 1'b0;
  endtask

  task automatic test_outstanding();
    int n = 0;
    logic g, exp_g;
    logic [1:0] exp_o;
    do_reset();
    ram_rdy = 1'b1; avl_ready = 1'b1; rd_req = 1'b1; rd_addr = AW'(29'h40);
    for (int c = 0; c <= 14; c++) begin
      avl_rdata_valid = (c == 12);
      avl_rdata = 32'(c);
      @(negedge clk);
      exp_g = (c >= 1 && c <= 8) || c == 13;
      exp_o = (c == 0) ? 2'd0 : 2'd1;
      checks++; if (rd_gnt !== exp_g) begin failures++; $display("FAIL outst_gnt c=%0d got=%b exp=%b", c, rd_gnt, exp_g); end
      checks++; if (owner !== exp_o) begin failures++; $display("FAIL outst_owner c=%0d got=%0d exp=%0d", c, owner, exp_o); end
      if (c >= 9 && c <= 12) begin
        checks++; if (avl_read_req !== 1'b0) begin failures++; $display("FAIL outst_cmd c=%0d got=%b exp=0", c, avl_read_req); end
      end
      g = rd_gnt;
      @(posedge clk); #1;
      if (g) n++;
    end
    checks++; if (n !== 9) begin failures++; $display("FAIL outst_total got=%0d exp=9", n); end
    rd_req = 1'b0; avl_rdata_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ram_rdy = 1'b1; avl_ready = 1'b1; wr0_req = 1'b1;
    wr0_addr = AW'(29'h777); wr0_data = 32'h5555_AAAA;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL mid_pre_owner got=%0d exp=2", owner); end
    reset = 1'b0;
    #1;
    checks++; if (owner !== 2'd0 || avl_write_req !== 1'b0 || wr0_gnt !== 1'b0) begin
      failures++; $display("FAIL mid_abort got=o%0d w%b g%b exp=o0 w0 g0", owner, avl_write_req, wr0_gnt);
    end
    checks++; if (avl_addr !== '0 || avl_wdata !== '0) begin failures++; $display("FAIL mid_bus got=%h/%h exp=0/0", avl_addr, avl_wdata); end
    wr0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    avl_rdata = 32'h1234_5678; avl_rdata_valid = 1'b1;
    @(posedge clk); #1;
    avl_rdata_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_data_valid !== 1'b1 || rd_data !== 32'h1234_5678) begin
      failures++; $display("FAIL mid_forward got=%b/%h exp=1/12345678", rd_data_valid, rd_data);
    end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL mid_post_owner got=%0d exp=0", owner); end
    // An unmatched return must not leave the read window blocked or wrapped
    @(posedge clk); #1;
    rd_req = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL mid_read_after got=%b exp=1", rd_gnt); end
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_wr0_burst();
    test_round_robin();
    test_rd_priority();
    test_stall();
    test_outstanding();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
